branch_resolution_queue: RTL and testbench
==========================================

BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight predicted branches held (power of two, >=2).
REQ-002 SHALL have parameter XLEN, default 32, PC/target width.
REQ-003 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; reset input 1, synchronous active-high reset.
REQ-004 pred_valid  input  1  fetch presents a predicted branch.
REQ-005 pred_ready  output  1  queue can accept; high when count < DEPTH (registered count).
REQ-006 pred_pc  input  XLEN  PC of predicted branch.
REQ-007 pred_taken  input  1  predicted direction.
REQ-008 pred_target  input  XLEN  predicted target (ignored when pred_taken=0).
REQ-009 res_valid  input  1  execute resolves oldest in-flight branch (in order).
REQ-010 res_taken  input  1  actual direction.
REQ-011 res_target  input  XLEN  actual taken target.
REQ-012 upd_valid  output  1  one-cycle predictor training pulse.
REQ-013 upd_pc / upd_taken / upd_target  output  XLEN/1/XLEN  training data: head PC, actual outcome.
REQ-014 redirect_valid  output  1  one-cycle mispredict pulse to fetch.
REQ-015 redirect_pc  output  XLEN  correct next PC.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-017 underflow  output  1  one-cycle pulse: res_valid while empty.

Function
REQ-018 Push SHALL occur on pred_valid && pred_ready; entry {pc, taken, target} written at tail, tail increments modulo DEPTH.
REQ-019 Pop SHALL occur on res_valid && count!=0; head entry compared, head increments modulo DEPTH.
REQ-020 Mispredict SHALL be: pred_taken!=res_taken, or both taken and pred_target!=res_target.
REQ-021 upd_valid SHALL pulse exactly one cycle after every pop, with upd_pc=head pc, upd_taken=res_taken, upd_target=res_target.
REQ-022 redirect_valid SHALL pulse one cycle after a mispredicting pop; redirect_pc = res_target if res_taken else head pc+4 (mod 2^XLEN).
REQ-023 On a mispredicting pop all younger entries SHALL be flushed: count->0, tail->head+1, same edge.
REQ-024 A push in the same cycle as a mispredicting pop SHALL be discarded (wrong path).
REQ-025 Simultaneous push and non-mispredicting pop SHALL leave count unchanged; both take effect.
REQ-026 When full, pred_ready SHALL be 0 even if a pop occurs that cycle (no same-cycle bypass).
REQ-027 res_valid with count=0 SHALL cause no state change and pulse underflow next cycle; upd_valid/redirect_valid stay 0.
REQ-028 All outputs except pred_ready and count SHALL be registered; pred_ready and count derive only from registered state.

Reset
REQ-029 On reset: head=0, tail=0, count=0, upd_valid=0, redirect_valid=0, underflow=0, upd_*/redirect_pc=0; storage contents need not be cleared.
REQ-030 Reset asserted mid-operation SHALL override any same-cycle push/pop; pulses due next cycle SHALL be suppressed.

Structure
REQ-031 Shared package branch_pkg SHALL hold the entry struct typedef (pc, taken, target), DEPTH default and XLEN constants.
REQ-032 No sub-module; circular buffer, pointers, comparator and output registers live in one module (flush makes a generic FIFO unsuitable).

Verification
REQ-033 Push pc=0x100 taken=1 target=0x200; resolve taken=1 target=0x200 -> upd_valid 1 cycle later, upd_pc=0x100, redirect_valid=0, count 1->0.
REQ-034 Push 0x100 (not-taken), 0x104, 0x108; resolve first with taken=1 target=0x400 -> redirect_valid, redirect_pc=0x400, count=0, later res_valid gives underflow.
REQ-035 Push pc=0x300 taken=1 target=0x500; resolve taken=0 -> redirect_pc=0x304.
REQ-036 Fill to DEPTH=8 -> pred_ready=0; pop+push same cycle -> push not accepted, count=7; next cycle pred_ready=1.
REQ-037 With count=3, non-mispredicting pop and push same cycle -> count=3, FIFO order preserved across pointer wrap (run 20 push/pop pairs, upd_pc sequence matches push order).
REQ-038 Assert reset with count=5 and res_valid high -> next cycle count=0, upd_valid=0, redirect_valid=0, pred_ready=1.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and the entry layout for the branch resolution queue.
package branch_pkg;

  localparam int BRQ_DEPTH = 8;
  localparam int BRQ_XLEN  = 32;

  typedef struct packed {
    logic [BRQ_XLEN-1:0] pc;
    logic                taken;
    logic [BRQ_XLEN-1:0] target;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolution_queue.sv
// In-order queue of predicted branches; resolves the oldest entry, trains the
// predictor and redirects fetch (flushing younger entries) on a mispredict.
module branch_resolution_queue
  import branch_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int XLEN  = BRQ_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [XLEN-1:0]          pred_pc,
  input  logic                     pred_taken,
  input  logic [XLEN-1:0]          pred_target,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [XLEN-1:0]          res_target,
  output logic                     upd_valid,
  output logic [XLEN-1:0]          upd_pc,
  output logic                     upd_taken,
  output logic [XLEN-1:0]          upd_target,
  output logic                     redirect_valid,
  output logic [XLEN-1:0]          redirect_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a push happens on a cycle where pred_valid && pred_ready at the
  // rising edge; pred_ready depends only on registered occupancy. res_valid has
  // no ready: it pops whenever the queue is non-empty, else it is an underflow.

  brq_entry_t          mem_q [DEPTH];
  brq_entry_t          head_ent;
  brq_entry_t          new_ent;

  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic                upd_valid_q, upd_valid_d;
  logic [XLEN-1:0]     upd_pc_q, upd_pc_d;
  logic                upd_taken_q, upd_taken_d;
  logic [XLEN-1:0]     upd_target_q, upd_target_d;
  logic                redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;
  logic                underflow_q, underflow_d;

  logic                push, pop, mispredict, flush, push_ok;

  assign pred_ready = (count_q < CW'(DEPTH));

  always_comb begin
    head_ent         = mem_q[head_q];
    new_ent.pc       = pred_pc;
    new_ent.taken    = pred_taken;
    new_ent.target   = pred_target;

    push       = pred_valid && pred_ready;
    pop        = res_valid && (count_q != '0);
    mispredict = (head_ent.taken != res_taken) ||
                 (res_taken && (head_ent.target != res_target));
    flush      = pop && mispredict;
    // A push that coincides with a flush is fetched down the wrong path.
    push_ok    = push && !flush;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (pop)     head_d = head_q + PW'(1);
      if (push_ok) tail_d = tail_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_comb begin
    upd_valid_d      = pop;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_target_d     = upd_target_q;
    redirect_valid_d = flush;
    redirect_pc_d    = redirect_pc_q;
    underflow_d      = res_valid && (count_q == '0);
    if (pop) begin
      upd_pc_d     = head_ent.pc;
      upd_taken_d  = res_taken;
      upd_target_d = res_target;
    end
    if (flush) begin
      redirect_pc_d = res_taken ? res_target : (head_ent.pc + XLEN'(4));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      upd_valid_q      <= 1'b0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_target_q     <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      upd_valid_q      <= upd_valid_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_target_q     <= upd_target_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      underflow_q      <= underflow_d;
    end
  end

  // Storage is not reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[tail_q] <= new_ent;
    end
  end

  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign underflow      = underflow_q;
  assign count          = count_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Scoreboard bench for branch_resolution_queue: a queue-based reference model
// predicts every cycle's outputs; a monitor compares them after each edge.
module tb_branch_resolution_queue;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            rst;
    logic            upd;
    logic            unf;
    logic            redir;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] rpc;
  } exp_t;

  localparam int EW = $bits(exp_t);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic [XLEN-1:0] target;
  } m_ent_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            pred_valid, pred_ready, pred_taken;
  logic [XLEN-1:0] pred_pc, pred_target;
  logic            res_valid, res_taken;
  logic [XLEN-1:0] res_target;
  logic            upd_valid, upd_taken, redirect_valid, underflow;
  logic [XLEN-1:0] upd_pc, upd_target, redirect_pc;
  logic [CW-1:0]   count;

  int tests  = 0;
  int failed = 0;

  logic [EW-1:0] exp_q[$];
  m_ent_t        model_q[$];

  branch_resolution_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .count(count), .underflow(underflow)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
  end

  // Driver: applies one cycle of inputs and records what the model expects
  // to see right after the coming rising edge.
  task automatic step(input logic rst, input logic pv, input logic [XLEN-1:0] ppc,
                      input logic pt, input logic [XLEN-1:0] ptg,
                      input logic rv, input logic rt, input logic [XLEN-1:0] rtg);
    exp_t   r;
    m_ent_t e;
    logic   can_push, mis;
    @(negedge clk);
    reset = rst; pred_valid = pv; pred_pc = ppc; pred_taken = pt;
    pred_target = ptg; res_valid = rv; res_taken = rt; res_target = rtg;
    r = '0;
    if (rst) begin
      r.rst = 1'b1;
      model_q.delete();
    end else begin
      can_push = pv && (model_q.size() < DEPTH);
      if (rv && model_q.size() == 0) begin
        r.unf = 1'b1;
      end else if (rv) begin
        e        = model_q.pop_front();
        r.upd    = 1'b1;
        r.pc     = e.pc;
        r.taken  = rt;
        r.target = rtg;
        mis = (e.taken != rt) || (rt && (e.target != rtg));
        if (mis) begin
          r.redir = 1'b1;
          r.rpc   = rt ? rtg : e.pc + 32'd4;
          model_q.delete();
          can_push = 1'b0;
        end
      end
      if (can_push) model_q.push_back('{pc: ppc, taken: pt, target: ptg});
    end
    r.cnt = CW'(model_q.size());
    exp_q.push_back(r);
    @(posedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic push_br(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg);
    step(1'b0, 1'b1, pc, t, tg, 1'b0, 1'b0, '0);
  endtask

  task automatic resolve(input logic t, input logic [XLEN-1:0] tg);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, t, tg);
  endtask

  // Resolve the head exactly as predicted while pushing a new branch.
  task automatic pop_push_ok(input logic [XLEN-1:0] pc);
    logic t; logic [XLEN-1:0] tg;
    t  = model_q[0].taken;
    tg = model_q[0].target;
    step(1'b0, 1'b1, pc, 1'b0, '0, 1'b1, t, tg);
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    exp_t r;
    #1;
    if (exp_q.size() > 0) begin
      r = exp_t'(exp_q.pop_front());
      tests++;
      if ({upd_valid, underflow, redirect_valid, count, pred_ready} !==
          {r.upd, r.unf, r.redir, r.cnt, (r.cnt < CW'(DEPTH))}) begin
        failed++;
        $display("FAIL ctrl t=%0t got upd=%b unf=%b redir=%b cnt=%0d rdy=%b exp upd=%b unf=%b redir=%b cnt=%0d rdy=%b",
                 $time, upd_valid, underflow, redirect_valid, count, pred_ready,
                 r.upd, r.unf, r.redir, r.cnt, (r.cnt < CW'(DEPTH)));
      end
      if (r.upd || r.rst) begin
        tests++;
        if ({upd_pc, upd_taken, upd_target} !== {r.pc, r.taken, r.target}) begin
          failed++;
          $display("FAIL upd_data t=%0t got pc=%h tk=%b tg=%h exp pc=%h tk=%b tg=%h",
                   $time, upd_pc, upd_taken, upd_target, r.pc, r.taken, r.target);
        end
      end
      if (r.redir || r.rst) begin
        tests++;
        if (redirect_pc !== r.rpc) begin
          failed++;
          $display("FAIL redirect_pc t=%0t got %h exp %h", $time, redirect_pc, r.rpc);
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] pc, tg;
    logic pv, rv, pt, rt;
    // Reset
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    idle();

    // Correct taken prediction
    push_br(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 32'h200);
    idle();

    // Not-taken predicted, actually taken: flush and later underflow
    push_br(32'h100, 1'b0, 32'h0);
    push_br(32'h104, 1'b0, 32'h0);
    push_br(32'h108, 1'b0, 32'h0);
    resolve(1'b1, 32'h400);
    idle();
    resolve(1'b0, 32'h0);
    idle();

    // Taken predicted, actually not taken: fall-through redirect
    push_br(32'h300, 1'b1, 32'h500);
    resolve(1'b0, 32'h0);
    idle();

    // Taken both ways but wrong target, with a wrong-path push
    push_br(32'h600, 1'b1, 32'h700);
    step(1'b0, 1'b1, 32'h604, 1'b0, '0, 1'b1, 1'b1, 32'h780);
    idle();

    // Fill; pop+push while full must not accept the push
    for (int i = 0; i < DEPTH; i++) push_br(32'h1000 + 32'(i * 4), 1'b0, '0);
    push_br(32'hdead, 1'b0, '0);
    pop_push_ok(32'hbeef);
    push_br(32'h2000, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) resolve(model_q[0].taken, model_q[0].target);
    idle();

    // count=3 steady state, pointer wrap
    for (int i = 0; i < 3; i++) push_br(32'h3000 + 32'(i * 4), 1'b1, 32'h9000 + 32'(i));
    for (int i = 0; i < 20; i++) pop_push_ok(32'h4000 + 32'(i * 4));
    idle();

    // Reset mid-operation with pending resolve and push
    for (int i = 0; i < 2; i++) resolve(model_q[0].taken, model_q[0].target);
    for (int i = 0; i < 4; i++) push_br(32'h5000 + 32'(i * 4), 1'b0, '0);
    step(1'b1, 1'b1, 32'h6000, 1'b0, '0, 1'b1, 1'b1, 32'h1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      pc = 32'($urandom_range(0, 255)) << 2;
      pt = $urandom_range(0, 1);
      tg = 32'($urandom_range(0, 3)) << 4;
      if (model_q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = model_q[0].taken;
        tg = model_q[0].taken ? model_q[0].target : tg;
        step(1'b0, pv, pc, pt, 32'($urandom_range(0, 3)) << 4, rv, rt, tg);
      end else begin
        rt = $urandom_range(0, 1);
        step($urandom_range(0, 99) == 0, pv, pc, pt, 32'($urandom_range(0, 3)) << 4,
             rv, rt, tg);
      end
    end
    idle();
    idle();
    #3;

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain got %0d pending exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
